result_accumulator: RTL and testbench
=====================================

RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 SHALL have parameter DATA_SIZE_ARB, default `DATA_SIZE_ARB from defines.v, coefficient width.
REQ-002 SHALL have parameter BEAT_W, default 8, width of beat-count input.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port modulus  input  DATA_SIZE_ARB  modulus q; static during operation.
REQ-006 SHALL have port beats  input  BEAT_W  words per group; sampled on first beat of each group.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port in_data  input  DATA_SIZE_ARB  reduced adder-tree result; caller guarantees in_data < q.
REQ-010 SHALL have port out_valid  output  1  out_data holds a completed group sum.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-012 SHALL have port out_data  output  DATA_SIZE_ARB  group sum mod q.

Function
REQ-013 SHALL transfer an input beat only when in_valid and in_ready are both high at a clock edge; same rule for output with out_valid/out_ready.
REQ-014 SHALL implement states IDLE (no partial sum), ACCUM (partial sum held), HOLD (result waiting).
REQ-015 SHALL drive in_ready = !out_valid || out_ready.
REQ-016 SHALL, on accepting a beat in IDLE/HOLD, load acc = in_data, latch beats into the remaining-count register, and go to ACCUM. If beats <= 1, SHALL instead go directly to HOLD with out_data = in_data.
REQ-017 SHALL, on a beat in ACCUM, form sum = acc + in_data at DATA_SIZE_ARB+1 bits; diff = sum - q at DATA_SIZE_ARB+2 bits; new acc = diff when diff MSB is 0, else sum[DATA_SIZE_ARB-1:0].
REQ-018 SHALL, when the last beat of a group is accepted, register the reduced sum into out_data, assert out_valid on the next cycle (latency 1 cycle after the last beat), and enter HOLD.
REQ-019 SHALL hold out_data and out_valid stable in HOLD until out_ready is high. Without a same-cycle new beat, SHALL then return to IDLE and deassert out_valid.
REQ-020 SHALL, when a result is taken and a new first beat is accepted in the same cycle, apply REQ-016 with no bubble.
REQ-021 SHALL ignore changes on beats after the first beat of a group.
REQ-022 SHALL treat beats = 0 as 1.
REQ-023 SHALL produce a fully reduced result (< q) in every case, including when acc + in_data = 2q-2.

Reset
REQ-024 SHALL, on reset, clear out_valid=0, out_data=0, acc=0, remaining count=0, state=IDLE; in_ready is 1 on the first cycle after reset.
REQ-025 SHALL discard a partial or held group on reset mid-operation; reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-026 SHALL support macro RESULT_ACC_NEGATE_EN. When defined, an extra input in_neg (1 bit, qualified with in_valid) SHALL subtract in_data modularly: new acc = acc - in_data, plus q on borrow. On a first beat with in_neg=1, acc SHALL load (q - in_data) mod q.
REQ-027 SHALL, when RESULT_ACC_NEGATE_EN is undefined, have no in_neg port and add only.

Verification (q = 12289, DATA_SIZE_ARB = 14)
REQ-028 SHALL cover: beats=3, inputs 12000, 300, 100 back-to-back, out_ready=1 -> out_valid one cycle after the third beat, out_data = 111.
REQ-029 SHALL cover: beats=1, input 5 -> out_data = 5 next cycle; beats=0, input 7 -> out_data = 7.
REQ-030 SHALL cover: beats=2, inputs 12288, 12288 -> out_data = 12287.
REQ-031 SHALL cover: out_ready=0 for 4 cycles after a result -> out_data stable, in_ready=0. Then out_ready=1 with a new first beat in the same cycle -> new group starts with no bubble.
REQ-032 SHALL cover: reset asserted after 2 of 4 beats -> out_valid=0. A following group beats=2, inputs 1, 2 -> out_data = 3.
REQ-033 SHALL cover, with RESULT_ACC_NEGATE_EN defined: beats=2, inputs 10 then 20 with in_neg=1 -> out_data = 12279.

Source files
------------

// File: rtl/result_accumulator.sv
// Modular group accumulator: sums `beats` input words mod q and presents the result over valid/ready.
// Optional RESULT_ACC_NEGATE_EN adds an in_neg input that subtracts in_data instead of adding it.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 14
`endif

module result_accumulator #(
  parameter int DATA_SIZE_ARB = `DATA_SIZE_ARB,
  parameter int BEAT_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_SIZE_ARB-1:0] modulus,
  input  logic [BEAT_W-1:0]        beats,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_SIZE_ARB-1:0] in_data,
`ifdef RESULT_ACC_NEGATE_EN
  input  logic                     in_neg,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_SIZE_ARB-1:0] out_data,
  output logic [1:0]               dbg_state
);

  // Handshake: a word moves on a rising edge only when its valid and ready are both high;
  // valid never waits on ready, and out_data/out_valid hold steady until taken.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int W = DATA_SIZE_ARB;

  state_t              state, state_n;
  logic [W-1:0]        acc, acc_n;
  logic [BEAT_W-1:0]   rem, rem_n;
  logic                out_valid_n;
  logic [W-1:0]        out_data_n;

  logic                accept;
  logic [W-1:0]        first_val;
  logic [W-1:0]        step_val;
  logic [W:0]          sum;
  logic [W+1:0]        diff;
  logic [W-1:0]        add_val;
  logic                unused_bits;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Conditional subtract keeps acc + in_data (< 2q) fully reduced.
  assign sum         = {1'b0, acc} + {1'b0, in_data};
  assign diff        = {1'b0, sum} - {2'b00, modulus};
  assign add_val     = diff[W+1] ? sum[W-1:0] : diff[W-1:0];
  assign unused_bits = diff[W];

`ifdef RESULT_ACC_NEGATE_EN
  logic [W:0]   sdiff;
  logic [W-1:0] sub_val;

  assign sdiff     = {1'b0, acc} - {1'b0, in_data};
  assign sub_val   = sdiff[W] ? (sdiff[W-1:0] + modulus) : sdiff[W-1:0];
  assign first_val = (in_neg && (in_data != '0)) ? (modulus - in_data) : (in_neg ? '0 : in_data);
  assign step_val  = in_neg ? sub_val : add_val;
`else
  assign first_val = in_data;
  assign step_val  = add_val;
`endif

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    rem_n       = rem;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    unique case (state)
      IDLE, HOLD: begin
        if (state == HOLD && out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
        // A first beat may arrive in the same cycle the held result is taken.
        if (accept) begin
          acc_n = first_val;
          if (beats <= BEAT_W'(1)) begin
            rem_n       = '0;
            out_data_n  = first_val;
            out_valid_n = 1'b1;
            state_n     = HOLD;
          end else begin
            rem_n       = beats - BEAT_W'(1);
            out_valid_n = 1'b0;
            state_n     = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_n = step_val;
          if (rem <= BEAT_W'(1)) begin
            rem_n       = '0;
            out_data_n  = step_val;
            out_valid_n = 1'b1;
            state_n     = HOLD;
          end else begin
            rem_n = rem - BEAT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      rem       <= rem_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: directed scenarios plus randomized traffic against a modular-sum model.
module tb_result_accumulator;
  localparam int W  = 14;
  localparam int BW = 8;
  localparam int Q  = 12289;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  modulus;
  logic [BW-1:0] beats;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_neg;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  result_accumulator #(.DATA_SIZE_ARB(W), .BEAT_W(BW)) dut (
    .clk(clk),
    .reset(reset),
    .modulus(modulus),
    .beats(beats),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef RESULT_ACC_NEGATE_EN
    .in_neg(in_neg),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .dbg_state(dbg_state)
  );

  task cyc();
    @(posedge clk);
    #1;
  endtask

  task beat(input int d, input int b, input bit neg);
    in_valid = 1'b1;
    in_data  = W'(d);
    beats    = BW'(b);
    in_neg   = neg;
    cyc();
    in_valid = 1'b0;
  endtask

  task test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; modulus = W'(Q);
    beats = '0; in_data = '0; in_neg = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    checks++;
  endtask

  task test_three_beats();
    out_ready = 1'b1;
    beat(12000, 3, 0);
    if (out_valid !== 1'b0) begin errors++; $display("FAIL three_mid_valid got %0b exp 0", out_valid); end
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL three_accum_state got %0d exp 1", dbg_state); end
    checks++;
    beat(300, 3, 0);
    beat(100, 3, 0);
    if (out_valid !== 1'b1) begin errors++; $display("FAIL three_valid got %0b exp 1", out_valid); end
    checks++;
    if (out_data !== W'(111)) begin errors++; $display("FAIL three_data got %0d exp 111", out_data); end
    checks++;
    cyc();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL three_drop got %0b exp 0", out_valid); end
    checks++;
  endtask

  task test_single_beat();
    out_ready = 1'b1;
    beat(5, 1, 0);
    if (out_valid !== 1'b1 || out_data !== W'(5)) begin
      errors++; $display("FAIL single_b1 got v=%0b d=%0d exp v=1 d=5", out_valid, out_data);
    end
    checks++;
    beat(7, 0, 0);
    if (out_valid !== 1'b1 || out_data !== W'(7)) begin
      errors++; $display("FAIL single_b0 got v=%0b d=%0d exp v=1 d=7", out_valid, out_data);
    end
    checks++;
    cyc();
  endtask

  task test_max_operands();
    out_ready = 1'b1;
    beat(12288, 2, 0);
    beat(12288, 2, 0);
    if (out_data !== W'(12287)) begin errors++; $display("FAIL max_data got %0d exp 12287", out_data); end
    checks++;
    cyc();
  endtask

  task test_beats_ignored();
    out_ready = 1'b1;
    beat(10, 3, 0);
    beat(20, 1, 0);
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_early got %0b exp 0", out_valid); end
    checks++;
    beat(30, 0, 0);
    if (out_valid !== 1'b1 || out_data !== W'(60)) begin
      errors++; $display("FAIL ignore_data got v=%0b d=%0d exp v=1 d=60", out_valid, out_data);
    end
    checks++;
    cyc();
  endtask

  task test_back_to_back();
    out_ready = 1'b0;
    beat(42, 1, 0);
    in_valid = 1'b1; in_data = W'(99); beats = BW'(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== W'(42)) begin
        errors++;
        $display("FAIL hold_stable cyc %0d got rdy=%0b v=%0b d=%0d exp rdy=0 v=1 d=42", i, in_ready, out_valid, out_data);
      end
      checks++;
      cyc();
    end
    out_ready = 1'b1; in_data = W'(1000); beats = BW'(2);
    @(negedge clk);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b exp 1", in_ready); end
    checks++;
    cyc();
    in_valid = 1'b0;
    if (out_valid !== 1'b0 || dbg_state !== 2'd1) begin
      errors++; $display("FAIL b2b_start got v=%0b st=%0d exp v=0 st=1", out_valid, dbg_state);
    end
    checks++;
    beat(2000, 7, 0);
    if (out_valid !== 1'b1 || out_data !== W'(3000)) begin
      errors++; $display("FAIL b2b_data got v=%0b d=%0d exp v=1 d=3000", out_valid, out_data);
    end
    checks++;
    cyc();
  endtask

  task test_reset_mid();
    out_ready = 1'b1;
    beat(1, 4, 0);
    beat(2, 4, 0);
    reset = 1'b1; in_valid = 1'b1; in_data = W'(5); beats = BW'(1);
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    if (out_valid !== 1'b0 || out_data !== '0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rstmid got v=%0b d=%0d st=%0d exp v=0 d=0 st=0", out_valid, out_data, dbg_state);
    end
    checks++;
    beat(1, 2, 0);
    beat(2, 2, 0);
    if (out_valid !== 1'b1 || out_data !== W'(3)) begin
      errors++; $display("FAIL rstmid_next got v=%0b d=%0d exp v=1 d=3", out_valid, out_data);
    end
    checks++;
    out_ready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rsthold got %0b exp 0", out_valid); end
    checks++;
    out_ready = 1'b1;
  endtask

`ifdef RESULT_ACC_NEGATE_EN
  task test_negate();
    out_ready = 1'b1;
    beat(10, 2, 0);
    beat(20, 2, 1);
    if (out_data !== W'(12279)) begin errors++; $display("FAIL neg_sub got %0d exp 12279", out_data); end
    checks++;
    beat(5, 1, 1);
    if (out_data !== W'(12284)) begin errors++; $display("FAIL neg_first got %0d exp 12284", out_data); end
    checks++;
    beat(0, 1, 1);
    if (out_data !== W'(0)) begin errors++; $display("FAIL neg_zero got %0d exp 0", out_data); end
    checks++;
    in_neg = 1'b0;
    cyc();
  endtask
`endif

  task test_random();
    int acc_m, cnt_m, len_m, v, drain;
    logic [W-1:0] e;
    bit negate;
`ifdef RESULT_ACC_NEGATE_EN
    negate = 1'b1;
`else
    negate = 1'b0;
`endif
    acc_m = 0; cnt_m = 0; len_m = 0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = W'($urandom_range(0, Q - 1));
      beats     = BW'($urandom_range(0, 5));
      in_neg    = negate ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %0b ov=%0b or=%0b", c, in_ready, out_valid, out_ready);
      end
      checks++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected cyc %0d got d=%0d exp none", c, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL rnd_data cyc %0d got %0d exp %0d", c, out_data, e); end
        end
        checks++;
      end
      if (in_valid && in_ready) begin
        v = in_neg ? (Q - int'(in_data)) % Q : int'(in_data);
        if (cnt_m == 0) begin
          len_m = (beats == 0) ? 1 : int'(beats);
          acc_m = v;
        end else begin
          acc_m = (acc_m + v) % Q;
        end
        cnt_m++;
        if (cnt_m == len_m) begin
          exp_q.push_back(W'(acc_m));
          cnt_m = 0;
        end
      end
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; in_neg = 1'b0;
    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(negedge clk);
      if (out_valid) begin
        e = exp_q.pop_front();
        if (out_data !== e) begin errors++; $display("FAIL rnd_drain got %0d exp %0d", out_data, e); end
        checks++;
      end
      cyc();
      drain++;
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_timeout got %0d pending exp 0", exp_q.size()); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_three_beats();
    test_single_beat();
    test_max_operands();
    test_beats_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef RESULT_ACC_NEGATE_EN
    test_negate();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
